logic_op_unit: RTL and testbench

LOGIC_OP_UNIT -- requirements
Module: logic_op_unit

---
 rtl/logic_op_unit.sv | 202 ++++++++++++++++++++
 tb/tb_logic_op_unit.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_unit.sv
// -----------------------------------------------------------------------------
// logic_op_unit
//
// Push-button logic calculator. Two W-bit banks of active-low operand keys
// (key_a, key_b) and one active-low mode key are synchronised and debounced
// individually. The debounced operand levels are inverted so that a pressed
// key reads as a logical 1. A four-state mode machine selects AND / OR /
// XOR / XNOR, and the selected bitwise operation is applied to the operands
// and registered every clock.
//
// Parameters
//   W         operand width in bits (1..16)
//   DEBOUNCE  consecutive stable cycles needed to accept a key change
//             (1..2^20)
//
// Ports
//   clk         single clock, all state updates on the rising edge
//   reset       asynchronous, active-high reset
//   key_a       operand A keys, active-low, asynchronous to clk
//   key_b       operand B keys, active-low, asynchronous to clk
//   key_mode    mode-advance key, active-low, asynchronous to clk
//   result      registered operation result, active-high
//   mode        current operation: 00 AND, 01 OR, 10 XOR, 11 XNOR
//   mode_pulse  one-cycle strobe on every mode change
// -----------------------------------------------------------------------------
module logic_op_unit #(
   parameter int W        = 4,
   parameter int DEBOUNCE = 50000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] key_a,
   input  logic [W-1:0] key_b,
   input  logic         key_mode,
   output logic [W-1:0] result,
   output logic [1:0]   mode,
   output logic         mode_pulse
);

   // Every key gets its own synchroniser and debouncer. Keys are packed
   // as {key_mode, key_b, key_a} so one generate loop covers all of them.
   localparam int NUM_KEYS = 2 * W + 1;

   // Counter wide enough to hold 0..DEBOUNCE; the terminal value is one
   // less than DEBOUNCE because the edge that accepts the change is the
   // DEBOUNCE-th edge of disagreement.
   localparam int              CNT_W    = $clog2(DEBOUNCE + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      MODE_AND  = 2'b00,
      MODE_OR   = 2'b01,
      MODE_XOR  = 2'b10,
      MODE_XNOR = 2'b11
   } mode_t;

   logic [NUM_KEYS-1:0] raw_keys;
   logic [NUM_KEYS-1:0] deb_level;

   logic [W-1:0] deb_a;
   logic [W-1:0] deb_b;
   logic         deb_mode;

   logic [W-1:0] operand_a;
   logic [W-1:0] operand_b;

   mode_t        state_q;
   mode_t        state_d;
   logic         pulse_q;
   logic         pulse_d;
   logic         deb_mode_q;
   logic         mode_press;

   logic [W-1:0] op_value;
   logic [W-1:0] result_q;

   assign raw_keys = {key_mode, key_b, key_a};

   // Per-key input conditioning. Each key sees a two-flop synchroniser
   // followed by a debouncer that only accepts a new level after the
   // synchronised value has disagreed with the current level for DEBOUNCE
   // consecutive edges. Any return to the current level before then wipes
   // the count, so short glitches never reach the debounced level.
   // Everything resets to the released (high) level so that a key held
   // through reset is seen afterwards as a fresh change.
   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      logic             meta_q;
      logic             sync_q;
      logic             level_q;
      logic [CNT_W-1:0] count_q;

      // Two-flop synchroniser; the first stage may go metastable, the
      // second stage is the only one anything downstream looks at.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
         end else begin
            meta_q <= raw_keys[k];
            sync_q <= meta_q;
         end
      end

      // Debouncer: count edges of disagreement between the synchronised
      // value and the accepted level, and adopt the new level on the edge
      // the count reaches its terminal value. With DEBOUNCE of 1 the
      // terminal value is zero, so the level simply follows one edge late.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            level_q <= 1'b1;
            count_q <= '0;
         end else if (sync_q == level_q) begin
            count_q <= '0;
         end else if (count_q == CNT_LAST) begin
            level_q <= sync_q;
            count_q <= '0;
         end else begin
            count_q <= count_q + CNT_ONE;
         end
      end

      assign deb_level[k] = level_q;
   end

   assign deb_a    = deb_level[W-1:0];
   assign deb_b    = deb_level[2*W-1:W];
   assign deb_mode = deb_level[2*W];

   // Keys are active-low, so a pressed key becomes a logical 1 here.
   assign operand_a = ~deb_a;
   assign operand_b = ~deb_b;

   // A press is the debounced mode key falling from released to pressed.
   // Comparing against a registered copy makes this a single-cycle event
   // no matter how long the key is held, so there is no auto-repeat, and
   // the release edge is ignored entirely.
   assign mode_press = deb_mode_q & ~deb_mode;

   // Mode state register, the strobe that accompanies each change, and
   // the delayed copy of the debounced mode key used for edge detection.
   // The delayed copy resets to released so a key held through reset
   // produces exactly one press once it is debounced again.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= MODE_AND;
         pulse_q    <= 1'b0;
         deb_mode_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         pulse_q    <= pulse_d;
         deb_mode_q <= deb_mode;
      end
   end

   // Next-state logic for the mode machine: on a press, step round the
   // ring AND -> OR -> XOR -> XNOR -> AND and raise the strobe for the
   // cycle in which the new mode first appears.
   always_comb begin
      state_d = state_q;
      pulse_d = 1'b0;
      if (mode_press) begin
         pulse_d = 1'b1;
         unique case (state_q)
            MODE_AND:  state_d = MODE_OR;
            MODE_OR:   state_d = MODE_XOR;
            MODE_XOR:  state_d = MODE_XNOR;
            MODE_XNOR: state_d = MODE_AND;
            default:   state_d = MODE_AND;
         endcase
      end
   end

   // Bitwise operation selected by the current mode. This reads the mode
   // register rather than its next value, so the result always lags a
   // mode change by one edge, exactly as it lags an operand change.
   always_comb begin
      op_value = '0;
      unique case (state_q)
         MODE_AND:  op_value = operand_a & operand_b;
         MODE_OR:   op_value = operand_a | operand_b;
         MODE_XOR:  op_value = operand_a ^ operand_b;
         MODE_XNOR: op_value = ~(operand_a ^ operand_b);
         default:   op_value = '0;
      endcase
   end

   // Output register for the result, so no input reaches an output
   // without passing through at least one flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         result_q <= '0;
      end else begin
         result_q <= op_value;
      end
   end

   assign result     = result_q;
   assign mode       = state_q;
   assign mode_pulse = pulse_q;

endmodule

// File: tb/tb_logic_op_unit.sv
// -----------------------------------------------------------------------------
// tb_logic_op_unit
//
// Bench for logic_op_unit with W=4, DEBOUNCE=4. A behavioural model tracks
// each key as "raw value two edges ago" plus a run length of disagreement
// with the accepted level, counts presses as falling edges of the accepted
// mode level, and applies the selected operation arithmetically. The model
// is compared with the DUT on every falling clock edge, and directed checks
// with fixed expected constants cover latency, glitch rejection, mode
// stepping, asynchronous reset and a mode key held through reset.
// -----------------------------------------------------------------------------
module tb_logic_op_unit;

   localparam int W        = 4;
   localparam int DEBOUNCE = 4;
   localparam int NUM_KEYS = 2 * W + 1;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] key_a;
   logic [W-1:0] key_b;
   logic         key_mode;
   logic [W-1:0] result;
   logic [1:0]   mode;
   logic         mode_pulse;

   int check_count = 0;
   int error_count = 0;
   int pulse_count = 0;
   int pulse_base;
   bit check_en = 1'b0;

   logic [NUM_KEYS-1:0] m_prev;
   logic [NUM_KEYS-1:0] m_sync;
   logic [NUM_KEYS-1:0] m_level;
   int                  m_run [NUM_KEYS];
   logic                m_mode_key_q;
   int                  m_mode;
   logic                m_pulse;
   logic [W-1:0]        m_result;
   logic [W-1:0]        m_a;
   logic [W-1:0]        m_b;

   logic [1:0]   exp_mode [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
   logic [W-1:0] exp_res  [4] = '{4'b1110, 4'b0110, 4'b1001, 4'b1000};

   logic_op_unit #(
      .W        (W),
      .DEBOUNCE (DEBOUNCE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .key_a      (key_a),
      .key_b      (key_b),
      .key_mode   (key_mode),
      .result     (result),
      .mode       (mode),
      .mode_pulse (mode_pulse)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Single comparison point: counts the check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         error_count++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Drive all keys shortly after the next rising edge, well clear of it.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic m);
      @(posedge clk);
      #2;
      key_a    = a;
      key_b    = b;
      key_mode = m;
   endtask

   // Reference model. All updates use the values held just before the
   // edge: the result from the old accepted levels and mode, a press from
   // the old accepted mode level versus its value one edge earlier, and
   // a key is accepted once it has disagreed for DEBOUNCE edges in a row.
   // A key value reaches the debouncer two edges after it was sampled.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_prev       = '1;
         m_sync       = '1;
         m_level      = '1;
         for (int i = 0; i < NUM_KEYS; i++) m_run[i] = 0;
         m_mode_key_q = 1'b1;
         m_mode       = 0;
         m_pulse      = 1'b0;
         m_result     = '0;
      end else begin
         m_a = ~m_level[W-1:0];
         m_b = ~m_level[2*W-1:W];
         case (m_mode)
            0:       m_result = m_a & m_b;
            1:       m_result = m_a | m_b;
            2:       m_result = m_a ^ m_b;
            default: m_result = ~(m_a ^ m_b);
         endcase
         m_pulse = m_mode_key_q && !m_level[2*W];
         if (m_pulse) m_mode = (m_mode + 1) % 4;
         m_mode_key_q = m_level[2*W];
         for (int i = 0; i < NUM_KEYS; i++) begin
            if (m_sync[i] != m_level[i]) begin
               m_run[i]++;
               if (m_run[i] == DEBOUNCE) begin
                  m_level[i] = m_sync[i];
                  m_run[i]   = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
         m_sync = m_prev;
         m_prev = {key_mode, key_b, key_a};
      end
   end

   // Continuous comparison against the model on every falling edge, plus
   // a running count of strobes seen from the DUT.
   always @(negedge clk) begin
      if (check_en && !reset) begin
         checkOutput("model_result", 32'(result), 32'(m_result));
         checkOutput("model_mode", 32'(mode), 32'(m_mode[1:0]));
         checkOutput("model_pulse", 32'(mode_pulse), 32'(m_pulse));
         if (mode_pulse) pulse_count++;
      end
   end

   initial begin
      reset    = 1'b1;
      key_a    = '1;
      key_b    = '1;
      key_mode = 1'b1;
      #1;
      checkOutput("reset_result", 32'(result), 32'h0);
      checkOutput("reset_mode", 32'(mode), 32'h0);
      checkOutput("reset_pulse", 32'(mode_pulse), 32'h0);
      repeat (3) @(posedge clk);
      #3 reset = 1'b0;
      check_en = 1'b1;

      // Idle after reset.
      repeat (20) @(posedge clk);
      #1;
      checkOutput("idle_result", 32'(result), 32'h0);
      checkOutput("idle_mode", 32'(mode), 32'h0);
      checkOutput("idle_pulse", 32'(mode_pulse), 32'h0);

      // Operand latency: A=1111, B=0101 visible exactly 7 edges later.
      applyStimulus(4'b0000, 4'b1010, 1'b1);
      repeat (6) @(posedge clk);
      #1 checkOutput("latency_early", 32'(result), 32'h0);
      @(posedge clk);
      #1 checkOutput("latency_edge7", 32'(result), 32'b0101);

      // Step through all four modes with A=1100, B=1010.
      applyStimulus(4'b0011, 4'b0101, 1'b1);
      repeat (10) @(posedge clk);
      #1 checkOutput("and_base", 32'(result), 32'b1000);
      for (int i = 0; i < 4; i++) begin
         pulse_base = pulse_count;
         applyStimulus(4'b0011, 4'b0101, 1'b0);
         repeat (10) @(posedge clk);
         applyStimulus(4'b0011, 4'b0101, 1'b1);
         repeat (10) @(posedge clk);
         #1;
         checkOutput("step_mode", 32'(mode), 32'(exp_mode[i]));
         checkOutput("step_result", 32'(result), 32'(exp_res[i]));
         checkOutput("step_pulses", 32'(pulse_count - pulse_base), 32'd1);
      end

      // Glitch on key_a[0]: 3 cycles low rejected, 4 cycles low accepted.
      applyStimulus(4'b1111, 4'b0000, 1'b1);
      repeat (10) @(posedge clk);
      #1 checkOutput("glitch_base", 32'(result), 32'h0);
      applyStimulus(4'b1110, 4'b0000, 1'b1);
      repeat (3) @(posedge clk);
      #2 key_a = 4'b1111;
      repeat (15) @(posedge clk);
      #1 checkOutput("glitch_reject", 32'(result), 32'h0);
      applyStimulus(4'b1110, 4'b0000, 1'b1);
      repeat (4) @(posedge clk);
      #2 key_a = 4'b1111;
      repeat (3) @(posedge clk);
      #1 checkOutput("glitch_accept", 32'(result), 32'b0001);
      repeat (10) @(posedge clk);

      // Bouncing mode key followed by a solid press: one advance.
      pulse_base = pulse_count;
      applyStimulus(4'b1111, 4'b0000, 1'b0);
      applyStimulus(4'b1111, 4'b0000, 1'b1);
      applyStimulus(4'b1111, 4'b0000, 1'b0);
      repeat (10) @(posedge clk);
      applyStimulus(4'b1111, 4'b0000, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("bounce_pulses", 32'(pulse_count - pulse_base), 32'd1);
      checkOutput("bounce_mode", 32'(mode), 32'b01);

      // Asynchronous reset in the middle of a key_b debounce.
      applyStimulus(4'b0000, 4'b0000, 1'b1);
      repeat (10) @(posedge clk);
      #1 checkOutput("pre_reset_or", 32'(result), 32'b1111);
      applyStimulus(4'b0000, 4'b0101, 1'b1);
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      checkOutput("async_result", 32'(result), 32'h0);
      checkOutput("async_mode", 32'(mode), 32'h0);
      checkOutput("async_pulse", 32'(mode_pulse), 32'h0);
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      repeat (6) @(posedge clk);
      #1 checkOutput("release_early", 32'(result), 32'h0);
      @(posedge clk);
      #1 checkOutput("release_accept", 32'(result), 32'b1010);

      // Mode key held through reset release counts as one new press.
      applyStimulus(4'b0000, 4'b0101, 1'b0);
      repeat (10) @(posedge clk);
      #3 reset = 1'b1;
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      pulse_base = pulse_count;
      repeat (12) @(posedge clk);
      #1;
      checkOutput("held_mode", 32'(mode), 32'b01);
      checkOutput("held_pulses", 32'(pulse_count - pulse_base), 32'd1);
      applyStimulus(4'b0000, 4'b0101, 1'b1);
      repeat (10) @(posedge clk);

      // Random key activity with hold times around the debounce length.
      for (int i = 0; i < 120; i++) begin
         applyStimulus(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 7)) @(posedge clk);
      end
      repeat (20) @(posedge clk);
      #1;
      check_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors",
               check_count, error_count);
      $finish;
   end

endmodule
